// File: rtl/dk_loader_pkg.sv
// Shared types and constants for the DK ROM loader: sequencer states,
// ROM region bounds and ioctl stream indices.
package dk_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  typedef struct packed {
    logic cpu;
    logic snd;
    logic wav;
  } region_t;

  localparam logic [24:0] CPU_END  = 25'h000_8000;
  localparam logic [24:0] SND_BASE = 25'h000_E000;
  localparam logic [24:0] SND_END  = 25'h000_F000;
  localparam logic [24:0] WAV_BASE = 25'h001_0000;
  localparam logic [24:0] WAV_END  = 25'h002_0000;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

endpackage

// File: rtl/dk_region_decode.sv
// Combinational ROM address decoder: maps a download byte address to a
// one-hot {cpu, snd, wav} hit, or no hit for unmapped addresses.
module dk_region_decode
  import dk_loader_pkg::*;
(
  input  logic [24:0] i_addr,
  output region_t     o_hit
);

  // Region windows are disjoint, so at most one hit bit is ever set.
  always_comb begin
    o_hit     = '0;
    o_hit.cpu = (i_addr < CPU_END);
    o_hit.snd = (i_addr >= SND_BASE) && (i_addr < SND_END);
    o_hit.wav = (i_addr >= WAV_BASE) && (i_addr < WAV_END);
  end

endmodule

// File: rtl/dk_rom_loader.sv
// ioctl download sequencer for the DK core: ROM write ports, game-select and
// DIP capture, core reset ownership. Optional image checksum under ROM_CSUM_EN.
module dk_rom_loader
  import dk_loader_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024,
  parameter int MIN_BYTES   = 'h10000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        cpu_we,
  output logic        snd_we,
  output logic        wav_we,
  output logic [7:0]  mod,
  output logic [63:0] dip_sw,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] csum
);

  localparam int              HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]   HOLD_INIT = HW'(HOLD_CYCLES - 1);
  localparam logic [16:0]     MIN_CNT   = 17'(MIN_BYTES);
  localparam logic [16:0]     CNT_MAX   = 17'h1_FFFF;

  state_t        r_state;
  state_t        w_next;
  logic          r_dl;
  logic          w_rise_rom;
  logic          w_fall;
  logic          w_rom_wr;
  logic          w_enter_load;
  region_t       w_hit;
  logic [16:0]   r_cnt;
  logic [16:0]   w_cnt_inc;
  logic [HW-1:0] r_hold;
  logic [15:0]   r_rom_addr;
  logic [7:0]    r_rom_data;
  logic          r_cpu_we;
  logic          r_snd_we;
  logic          r_wav_we;
  logic [7:0]    r_mod;
  logic [63:0]   r_dip;
  logic          r_core_reset;
  logic          r_load_done;
  logic          r_load_err;

  dk_region_decode u_decode (
    .i_addr (ioctl_addr),
    .o_hit  (w_hit)
  );

  assign w_rise_rom   = ioctl_download && !r_dl && (ioctl_index == IDX_ROM);
  assign w_fall       = !ioctl_download && r_dl;
  assign w_rom_wr     = ioctl_wr && (ioctl_index == IDX_ROM) && (r_state == ST_LOAD);
  assign w_enter_load = (w_next == ST_LOAD) && (r_state != ST_LOAD);
  // Includes a byte landing on the falling-edge cycle in the accept decision.
  assign w_cnt_inc    = (w_rom_wr && (r_cnt != CNT_MAX)) ? r_cnt + 17'd1 : r_cnt;

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_rise_rom) w_next = ST_LOAD; else w_next = ST_IDLE;
      ST_LOAD: begin
        if (w_fall) w_next = (w_cnt_inc >= MIN_CNT) ? ST_HOLD : ST_ERR;
        else        w_next = ST_LOAD;
      end
      ST_HOLD: if (r_hold == '0) w_next = ST_RUN; else w_next = ST_HOLD;
      ST_RUN:  if (w_rise_rom) w_next = ST_LOAD; else w_next = ST_RUN;
      ST_ERR:  if (w_rise_rom) w_next = ST_LOAD; else w_next = ST_ERR;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register and download-level history for edge detection.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_dl    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dl    <= ioctl_download;
    end
  end

  // Byte counter and post-download hold timer.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_cnt  <= 17'd0;
      r_hold <= '0;
    end else begin
      r_cnt <= w_enter_load ? 17'd0 : w_cnt_inc;
      if ((w_next == ST_HOLD) && (r_state != ST_HOLD)) r_hold <= HOLD_INIT;
      else if ((r_state == ST_HOLD) && (r_hold != '0)) r_hold <= r_hold - 1'b1;
      else                                             r_hold <= r_hold;
    end
  end

  // Registered ROM write port; address and data hold their last value.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_rom_addr <= 16'h0000;
      r_rom_data <= 8'h00;
      r_cpu_we   <= 1'b0;
      r_snd_we   <= 1'b0;
      r_wav_we   <= 1'b0;
    end else begin
      r_cpu_we <= w_rom_wr && w_hit.cpu;
      r_snd_we <= w_rom_wr && w_hit.snd;
      r_wav_we <= w_rom_wr && w_hit.wav;
      if (w_rom_wr) begin
        r_rom_addr <= ioctl_addr[15:0];
        r_rom_data <= ioctl_dout;
      end
    end
  end

  // Game-select and DIP capture run in every state without touching the FSM.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_mod <= 8'h00;
      r_dip <= 64'h0;
    end else begin
      if (ioctl_wr && (ioctl_index == IDX_MOD)) r_mod <= ioctl_dout;
      if (ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == 22'd0))
        r_dip[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
    end
  end

  // Status flags follow the next state so they line up with the state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_core_reset <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_core_reset <= (w_next != ST_RUN);
      r_load_done  <= (w_next == ST_RUN);
      r_load_err   <= (w_next == ST_ERR);
    end
  end

`ifdef ROM_CSUM_EN
  logic [15:0] r_csum;

  // Image checksum, cleared on LOAD entry and frozen outside LOAD.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)             r_csum <= 16'h0000;
    else if (w_enter_load) r_csum <= 16'h0000;
    else if (w_rom_wr)     r_csum <= r_csum + {8'h00, ioctl_dout};
    else                   r_csum <= r_csum;
  end

  assign csum = r_csum;
`else
  assign csum = 16'h0000;
`endif

  assign rom_addr   = r_rom_addr;
  assign rom_data   = r_rom_data;
  assign cpu_we     = r_cpu_we;
  assign snd_we     = r_snd_we;
  assign wav_we     = r_wav_we;
  assign mod        = r_mod;
  assign dip_sw     = r_dip;
  assign core_reset = r_core_reset;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_dk_rom_loader.sv
// Self-checking bench for dk_rom_loader: randomized ROM streams against a
// behavioural region/count/checksum model, plus reset, DIP, mod and hold timing.
module tb_dk_rom_loader;

  localparam int HOLD = 1024;
  localparam int MINB = 'h1000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        cpu_we, snd_we, wav_we;
  logic [7:0]  mod;
  logic [63:0] dip_sw;
  logic        core_reset, load_done, load_err;
  logic [15:0] csum;

  int errors = 0;
  int checks = 0;
  int obs_cpu, obs_snd, obs_wav, exp_cpu, exp_snd, exp_wav, bad;
  logic [15:0] sum_model;
  logic [7:0]  exp_dip [8];
  logic [7:0]  exp_mod;

  always #5 clk_sys = ~clk_sys;

  dk_rom_loader #(.HOLD_CYCLES(HOLD), .MIN_BYTES(MINB)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .rom_addr(rom_addr), .rom_data(rom_data),
    .cpu_we(cpu_we), .snd_we(snd_we), .wav_we(wav_we), .mod(mod),
    .dip_sw(dip_sw), .core_reset(core_reset), .load_done(load_done),
    .load_err(load_err), .csum(csum)
  );

  function automatic logic [15:0] csum_model();
`ifdef ROM_CSUM_EN
    return sum_model;
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [63:0] dip_model();
    logic [63:0] v = 64'h0;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = exp_dip[k];
    return v;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Drives one index-0 download; tallies expected vs observed strobes.
  task automatic stream_rom(input int n, input int amode, input int dmode, input bit on_fall);
    logic [24:0] a;
    logic [7:0]  d;
    logic [24:0] bnd [12];
    bit ec, es, ew;
    bnd = '{25'h0, 25'h7FFF, 25'h8000, 25'hDFFF, 25'hE000, 25'hEFFF,
            25'hF000, 25'hFFFF, 25'h10000, 25'h1FFFF, 25'h20000, 25'h1FFFFFF};
    obs_cpu = 0; obs_snd = 0; obs_wav = 0;
    exp_cpu = 0; exp_snd = 0; exp_wav = 0;
    bad = 0; sum_model = 16'h0000;
    @(negedge clk_sys);
    ioctl_index = 8'd0; ioctl_download = 1'b1; ioctl_wr = 1'b0;
    wait_cycles(2);
    for (int i = 0; i < n; i++) begin
      if (amode == 0)   a = 25'((i * 16) % 'h10000);
      else if (i < 12)  a = bnd[i];
      else              a = 25'($urandom_range(0, 'h2FFFF));
      if (dmode == 0)                    d = 8'($urandom_range(0, 255));
      else if (dmode == 2 && i == n - 1) d = 8'h05;
      else                               d = 8'h10;
      ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
      if (on_fall && i == n - 1) ioctl_download = 1'b0;
      ec = (a < 25'h8000);
      es = (a >= 25'hE000) && (a < 25'hF000);
      ew = (a >= 25'h10000) && (a < 25'h20000);
      exp_cpu += int'(ec); exp_snd += int'(es); exp_wav += int'(ew);
      sum_model = sum_model + {8'h00, d};
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      obs_cpu += int'(cpu_we); obs_snd += int'(snd_we); obs_wav += int'(wav_we);
      if (cpu_we !== ec || snd_we !== es || wav_we !== ew) bad++;
      if ((ec || es || ew) && (rom_addr !== a[15:0] || rom_data !== d)) bad++;
    end
    if (!on_fall) ioctl_download = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = 8'd0; ioctl_addr = 25'd0; ioctl_dout = 8'd0;
    for (int k = 0; k < 8; k++) exp_dip[k] = 8'h00;
    exp_mod = 8'h00;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset got=%b exp=1", core_reset); end
    checks++; if ({load_done, load_err} !== 2'b00) begin errors++; $display("FAIL rst_flags got=%b exp=00", {load_done, load_err}); end
    checks++; if ({cpu_we, snd_we, wav_we} !== 3'b000) begin errors++; $display("FAIL rst_we got=%b exp=000", {cpu_we, snd_we, wav_we}); end
    checks++; if ({rom_addr, rom_data, mod, csum} !== 48'h0) begin errors++; $display("FAIL rst_regs got=%h exp=0", {rom_addr, rom_data, mod, csum}); end
    checks++; if (dip_sw !== 64'h0) begin errors++; $display("FAIL rst_dip got=%h exp=0", dip_sw); end
  endtask

  task automatic test_rom_seq;
    stream_rom(MINB, 0, 0, 1'b1);
    checks++; if (bad !== 0) begin errors++; $display("FAIL seq_strobes got=%0d bad exp=0", bad); end
    checks++; if (obs_cpu !== 'h800) begin errors++; $display("FAIL seq_cpu_count got=%0d exp=%0d", obs_cpu, 'h800); end
    checks++; if (obs_snd !== 'h100) begin errors++; $display("FAIL seq_snd_count got=%0d exp=%0d", obs_snd, 'h100); end
    checks++; if (obs_wav !== 0) begin errors++; $display("FAIL seq_wav_count got=%0d exp=0", obs_wav); end
    wait_cycles(HOLD - 1);
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL seq_hold_end got=%b exp=1", core_reset); end
    checks++; if (csum !== csum_model()) begin errors++; $display("FAIL seq_csum got=%h exp=%h", csum, csum_model()); end
    wait_cycles(1);
    checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL seq_run_start got=%b exp=0", core_reset); end
    checks++; if ({load_done, load_err} !== 2'b10) begin errors++; $display("FAIL seq_flags got=%b exp=10", {load_done, load_err}); end
  endtask

  task automatic test_mod_in_run;
    int viol = 0;
    @(negedge clk_sys); ioctl_index = 8'd1; ioctl_download = 1'b1;
    @(negedge clk_sys); ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h02; exp_mod = 8'h02;
    if (core_reset !== 1'b0) viol++;
    @(negedge clk_sys); ioctl_wr = 1'b0;
    checks++; if (mod !== exp_mod) begin errors++; $display("FAIL mod_value got=%h exp=%h", mod, exp_mod); end
    ioctl_download = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      if (core_reset !== 1'b0) viol++;
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL mod_core_reset got=%0d high cycles exp=0", viol); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL mod_load_done got=%b exp=1", load_done); end
  endtask

  task automatic test_rom_rand;
    stream_rom(MINB, 1, 0, 1'b0);
    checks++; if (bad !== 0) begin errors++; $display("FAIL rand_strobes got=%0d bad exp=0", bad); end
    checks++; if ({obs_cpu, obs_snd, obs_wav} !== {exp_cpu, exp_snd, exp_wav}) begin
      errors++; $display("FAIL rand_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", obs_cpu, obs_snd, obs_wav, exp_cpu, exp_snd, exp_wav);
    end
    wait_cycles(HOLD + 3);
    checks++; if ({core_reset, load_done} !== 2'b01) begin errors++; $display("FAIL rand_run got=%b exp=01", {core_reset, load_done}); end
    checks++; if (csum !== csum_model()) begin errors++; $display("FAIL rand_csum got=%h exp=%h", csum, csum_model()); end
  endtask

  task automatic test_short;
    int viol = 0;
    stream_rom('h100, 0, 0, 1'b1);
    wait_cycles(3);
    checks++; if ({core_reset, load_done, load_err} !== 3'b101) begin errors++; $display("FAIL short_flags got=%b exp=101", {core_reset, load_done, load_err}); end
    for (int k = 0; k < HOLD + 20; k++) begin
      @(negedge clk_sys);
      if (core_reset !== 1'b1) viol++;
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL short_core_reset got=%0d low cycles exp=0", viol); end
    stream_rom(MINB - 1, 1, 0, 1'b1);
    wait_cycles(3);
    checks++; if (bad !== 0) begin errors++; $display("FAIL short_strobes got=%0d bad exp=0", bad); end
    checks++; if ({load_done, load_err} !== 2'b01) begin errors++; $display("FAIL short_min_minus1 got=%b exp=01", {load_done, load_err}); end
  endtask

  task automatic test_dip;
    logic [24:0] wa [4];
    logic [7:0]  wd [4];
    wa = '{25'd0, 25'd9, 25'd3, 25'd8};
    wd = '{8'hA5, 8'h3C, 8'($urandom_range(0, 255)), 8'h77};
    @(negedge clk_sys); ioctl_index = 8'd254; ioctl_download = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      ioctl_wr = 1'b1; ioctl_addr = wa[k]; ioctl_dout = wd[k];
      if (wa[k] < 25'd8) exp_dip[wa[k][2:0]] = wd[k];
    end
    @(negedge clk_sys); ioctl_wr = 1'b0; ioctl_download = 1'b0;
    wait_cycles(2);
    checks++; if (dip_sw[7:0] !== 8'hA5) begin errors++; $display("FAIL dip_byte0 got=%h exp=a5", dip_sw[7:0]); end
    checks++; if (dip_sw !== dip_model()) begin errors++; $display("FAIL dip_bank got=%h exp=%h", dip_sw, dip_model()); end
    checks++; if ({core_reset, load_err} !== 2'b11) begin errors++; $display("FAIL dip_state got=%b exp=11", {core_reset, load_err}); end
  endtask

  task automatic test_reset_mid_hold;
    stream_rom(MINB, 1, 0, 1'b1);
    wait_cycles(10);
    checks++; if ({core_reset, load_done, load_err} !== 3'b100) begin errors++; $display("FAIL mid_hold_state got=%b exp=100", {core_reset, load_done, load_err}); end
    reset = 1'b1;
    #1;
    exp_mod = 8'h00;
    for (int k = 0; k < 8; k++) exp_dip[k] = 8'h00;
    checks++; if ({core_reset, load_done, load_err} !== 3'b100) begin errors++; $display("FAIL mid_hold_reset got=%b exp=100", {core_reset, load_done, load_err}); end
    checks++; if ({mod, dip_sw} !== {exp_mod, dip_model()}) begin errors++; $display("FAIL mid_hold_regs got=%h exp=%h", {mod, dip_sw}, {exp_mod, dip_model()}); end
    @(negedge clk_sys); reset = 1'b0;
    wait_cycles(HOLD + 5);
    checks++; if ({core_reset, load_done} !== 2'b10) begin errors++; $display("FAIL mid_hold_idle got=%b exp=10", {core_reset, load_done}); end
    stream_rom(MINB, 1, 0, 1'b1);
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_hold_strobes got=%0d bad exp=0", bad); end
    wait_cycles(HOLD + 2);
    checks++; if ({core_reset, load_done} !== 2'b01) begin errors++; $display("FAIL mid_hold_rerun got=%b exp=01", {core_reset, load_done}); end
  endtask

  task automatic test_csum;
    logic [15:0] want;
    stream_rom(MINB, 0, 1, 1'b1);
    wait_cycles(5);
`ifdef ROM_CSUM_EN
    want = 16'h0000;
`else
    want = 16'h0000;
`endif
    checks++; if (csum !== want || csum !== csum_model()) begin errors++; $display("FAIL csum_wrap got=%h exp=%h", csum, want); end
    wait_cycles(HOLD);
    stream_rom(MINB + 1, 0, 2, 1'b1);
    wait_cycles(5);
`ifdef ROM_CSUM_EN
    want = 16'h0005;
`else
    want = 16'h0000;
`endif
    checks++; if (csum !== want || csum !== csum_model()) begin errors++; $display("FAIL csum_plus5 got=%h exp=%h", csum, want); end
    wait_cycles(HOLD);
    checks++; if ({core_reset, load_done} !== 2'b01) begin errors++; $display("FAIL csum_run got=%b exp=01", {core_reset, load_done}); end
  endtask

  initial begin
    test_reset();
    test_rom_seq();
    test_mod_in_run();
    test_rom_rand();
    test_short();
    test_dip();
    test_reset_mid_hold();
    test_csum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
